// File: rtl/uart_master_tx_if.sv
// rtl/uart_master_tx_if.sv - Request/serial-line bundle between a UART TX client and the transmitter.
interface uart_master_tx_if #(
  parameter int DATA_W = 8
);
  logic              en_tx;
  logic [DATA_W-1:0] data;
  logic              u_tx;
  logic              u_tx_busy;
  logic              u_tx_done;

  modport master (
    output en_tx,
    output data,
    input  u_tx,
    input  u_tx_busy,
    input  u_tx_done
  );

  modport slave (
    input  en_tx,
    input  data,
    output u_tx,
    output u_tx_busy,
    output u_tx_done
  );
endinterface

// File: rtl/uart_master_tx.sv
// rtl/uart_master_tx.sv - UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (11-bit frames).
module uart_master_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_master_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_q, tx_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              bit_end;

  assign bit_end       = (clk_cnt == CNT_LAST);
  assign bus.u_tx      = tx_q;
  assign bus.u_tx_busy = busy_q;
  assign bus.u_tx_done = done_q;

  // Outputs are registered; the async reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    if (state != IDLE) begin
      clk_cnt_n = bit_end ? '0 : clk_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        tx_n      = 1'b1;
        busy_n    = 1'b0;
        clk_cnt_n = '0;
        if (bus.en_tx) begin
          state_n = START;
          shreg_n = bus.data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shreg[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^shreg;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
            tx_n      = shreg[bit_idx_n];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif

      STOP: begin
        // Busy drops and done pulses together so a request in the done cycle is taken next edge.
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_master_tx.sv
// tb/tb_uart_master_tx.sv - Self-checking bench for uart_master_tx (honours UART_TX_PARITY_EN).
module tb_uart_master_tx;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int N         = 11;
  localparam int FRAME_LIT = 176;
`else
  localparam int N         = 10;
  localparam int FRAME_LIT = 160;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_master_tx_if bus ();

  uart_master_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int m_t0     = 0;
  bit active   = 1'b0;
  bit chk_en   = 1'b0;
  logic [10:0] m_bits = '0;
  logic [3:0]  m_idx;
  logic e_tx, e_busy, e_done;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: a frame is a list of N line levels, each held C cycles from the acceptance edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      active = 1'b0;
    end else if (bus.en_tx === 1'b1 && (!active || cyc > m_t0 + N * C)) begin
      active = 1'b1;
      m_t0   = cyc;
`ifdef UART_TX_PARITY_EN
      m_bits = {1'b1, ^bus.data, bus.data, 1'b0};
`else
      m_bits = {1'b1, 1'b1, bus.data, 1'b0};
`endif
    end
  end

  always @(negedge clk) begin
    if (bus.u_tx_done === 1'b1) done_cnt++;
    if (chk_en) begin
      if (rst) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else if (active && cyc < m_t0 + N * C) begin
        m_idx  = 4'((cyc - m_t0) / C);
        e_tx   = m_bits[m_idx];
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = active && (cyc == m_t0 + N * C);
      end
      check("cyc_u_tx", int'(bus.u_tx), int'(e_tx));
      check("cyc_busy", int'(bus.u_tx_busy), int'(e_busy));
      check("cyc_done", int'(bus.u_tx_done), int'(e_done));
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, output int t0);
    @(negedge clk);
    #2;
    bus.en_tx = 1'b1;
    bus.data  = d;
    @(posedge clk);
    #1;
    bus.en_tx = 1'b0;
    bus.data  = ~d;
    t0 = m_t0;
  endtask

  task automatic capture(input int t0, output logic [10:0] s);
    s = '0;
    for (int k = 0; k < N; k++) begin
      wait_until(t0 + k * C + C / 2);
      s[4'(k)] = bus.u_tx;
    end
  endtask

  task automatic wait_done(input int limit, output int d);
    d = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.u_tx_done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: actual=no pulse required=pulse within %0d cycles", limit);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, d1, d2, c0;
    logic [10:0] s;
    logic [8:0]  exp_a5;

    bus.en_tx = 1'b0;
    bus.data  = '0;
    exp_a5    = 9'b1010_0101_0;

    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_u_tx", int'(bus.u_tx), 1);
    check("rst_busy", int'(bus.u_tx_busy), 0);
    check("rst_done", int'(bus.u_tx_done), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("idle_u_tx", int'(bus.u_tx), 1);
    check("idle_done_cnt", done_cnt, 0);

    send(8'hA5, t0);
    capture(t0, s);
    for (int k = 0; k < 9; k++) check($sformatf("a5_bit%0d", k), int'(s[4'(k)]), int'(exp_a5[4'(k)]));
    check("a5_stop", int'(s[4'(N - 1)]), 1);
    c0 = done_cnt;
    wait_done(2 * FRAME_LIT, d1);
    check("a5_done_lat", d1 - t0, FRAME_LIT);
    repeat (5) @(negedge clk);
    #1;
    check("a5_done_once", done_cnt - c0, 1);

    send(8'h00, t0);
    wait_done(2 * FRAME_LIT, d1);
    #2;
    bus.en_tx = 1'b1;
    bus.data  = 8'hFF;
    @(posedge clk);
    #1;
    bus.en_tx = 1'b0;
    bus.data  = 8'h00;
    t1 = m_t0;
    check("b2b_accept_edge", t1, d1 + 1);
    @(negedge clk);
    check("b2b_start_now", int'(bus.u_tx), 0);
    capture(t1, s);
    check("b2b_ff_data", int'(s[8:1]), 8'hFF);
    wait_done(2 * FRAME_LIT, d2);
    check("b2b_done_gap", d2 - d1, FRAME_LIT + 1);

    repeat (4) @(negedge clk);
    c0 = done_cnt;
    send(8'h3C, t0);
    fork
      capture(t0, s);
      begin
        wait_until(t0 + 50);
        #2;
        bus.en_tx = 1'b1;
        bus.data  = 8'hFF;
        @(posedge clk);
        #1;
        bus.en_tx = 1'b0;
      end
    join
    check("busy_3c_data", int'(s[8:1]), 8'h3C);
    wait_done(2 * FRAME_LIT, d1);
    check("busy_done_lat", d1 - t0, FRAME_LIT);
    repeat (2 * FRAME_LIT) @(negedge clk);
    #1;
    check("busy_one_done", done_cnt - c0, 1);

    send(8'h5A, t0);
    wait_until(t0 + 4 * C + 5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_u_tx", int'(bus.u_tx), 1);
    check("rst_mid_busy", int'(bus.u_tx_busy), 0);
    c0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - c0, 0);
    send(8'h81, t0);
    capture(t0, s);
    check("post_rst_data", int'(s[8:1]), 8'h81);
    wait_done(2 * FRAME_LIT, d1);
    check("post_rst_lat", d1 - t0, FRAME_LIT);

`ifdef UART_TX_PARITY_EN
    send(8'h07, t0);
    capture(t0, s);
    check("par07_bit", int'(s[9]), 1);
    wait_done(2 * FRAME_LIT, d1);
    check("par07_lat", d1 - t0, 176);
    send(8'h03, t0);
    capture(t0, s);
    check("par03_bit", int'(s[9]), 0);
    wait_done(2 * FRAME_LIT, d1);
    check("par03_lat", d1 - t0, 176);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
